// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use stall, flush and freeze.
//            Optional hazard statistics counters under HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_valid,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [4:0]  ID_rdes,
    input  logic        ID_uses_rt,
    input  logic        ID_RegWr,
    input  logic        ID_MemRd,
    input  logic        ID_MemWr,
    input  logic [5:0]  ID_ALUFun,
    input  logic [31:0] ID_busA,
    input  logic [31:0] ID_busB,
    input  logic [31:0] ID_imm,
    input  logic [31:0] ID_PC,
    input  logic        EX_flush,
    input  logic        MEM_busy,
    output logic        IDEX_valid,
    output logic [4:0]  IDEX_rs,
    output logic [4:0]  IDEX_rt,
    output logic [4:0]  IDEX_rdes,
    output logic        IDEX_RegWr,
    output logic        IDEX_MemRd,
    output logic        IDEX_MemWr,
    output logic [5:0]  IDEX_ALUFun,
    output logic [31:0] IDEX_busA,
    output logic [31:0] IDEX_busB,
    output logic [31:0] IDEX_imm,
    output logic [31:0] IDEX_PC,
    output logic        PC_Wr,
    output logic        IFID_Wr,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rdes;
        logic        regwr;
        logic        memrd;
        logic        memwr;
        logic [5:0]  alufun;
        logic [31:0] busa;
        logic [31:0] busb;
        logic [31:0] imm;
        logic [31:0] pc;
    } idex_t;

    idex_t idex_q;
    idex_t idex_d;
    idex_t w_id_fields;
    logic  w_load_use;
    logic  w_stall_ev;
    logic  w_flush_ev;

    assign w_load_use = ID_valid & idex_q.valid & idex_q.memrd & (idex_q.rdes != 5'd0) &
                        ((idex_q.rdes == ID_rs) | (ID_uses_rt & (idex_q.rdes == ID_rt)));

    // Control bits are qualified so an invalid slot can never write state.
    always_comb begin
        w_id_fields        = '0;
        w_id_fields.valid  = ID_valid;
        w_id_fields.rs     = ID_rs;
        w_id_fields.rt     = ID_rt;
        w_id_fields.rdes   = ID_rdes;
        w_id_fields.regwr  = ID_RegWr & ID_valid;
        w_id_fields.memrd  = ID_MemRd & ID_valid;
        w_id_fields.memwr  = ID_MemWr & ID_valid;
        w_id_fields.alufun = ID_ALUFun;
        w_id_fields.busa   = ID_busA;
        w_id_fields.busb   = ID_busB;
        w_id_fields.imm    = ID_imm;
        w_id_fields.pc     = ID_PC;
    end

    always_comb begin
        idex_d     = idex_q;
        PC_Wr      = 1'b1;
        IFID_Wr    = 1'b1;
        w_stall_ev = 1'b0;
        w_flush_ev = 1'b0;
        if (MEM_busy) begin
            PC_Wr   = 1'b0;
            IFID_Wr = 1'b0;
        end else if (EX_flush) begin
            idex_d     = '0;
            w_flush_ev = 1'b1;
        end else if (w_load_use) begin
            idex_d     = '0;
            PC_Wr      = 1'b0;
            IFID_Wr    = 1'b0;
            w_stall_ev = 1'b1;
        end else begin
            idex_d = w_id_fields;
        end
        // Fetch must keep running while the pipeline is held in reset.
        if (!rst_n) begin
            PC_Wr   = 1'b1;
            IFID_Wr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign IDEX_valid  = idex_q.valid;
    assign IDEX_rs     = idex_q.rs;
    assign IDEX_rt     = idex_q.rt;
    assign IDEX_rdes   = idex_q.rdes;
    assign IDEX_RegWr  = idex_q.regwr;
    assign IDEX_MemRd  = idex_q.memrd;
    assign IDEX_MemWr  = idex_q.memwr;
    assign IDEX_ALUFun = idex_q.alufun;
    assign IDEX_busA   = idex_q.busa;
    assign IDEX_busB   = idex_q.busb;
    assign IDEX_imm    = idex_q.imm;
    assign IDEX_PC     = idex_q.pc;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    // Saturating event counters; events are already masked by MEM_busy.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall_ev && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (w_flush_ev && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic w_unused_ev;
    assign w_unused_ev = w_stall_ev ^ w_flush_ev;
    assign stall_cnt   = 16'd0;
    assign flush_cnt   = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage (either build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        ID_valid;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic [4:0]  ID_rdes;
    logic        ID_uses_rt;
    logic        ID_RegWr;
    logic        ID_MemRd;
    logic        ID_MemWr;
    logic [5:0]  ID_ALUFun;
    logic [31:0] ID_busA;
    logic [31:0] ID_busB;
    logic [31:0] ID_imm;
    logic [31:0] ID_PC;
    logic        EX_flush;
    logic        MEM_busy;
    logic        IDEX_valid;
    logic [4:0]  IDEX_rs;
    logic [4:0]  IDEX_rt;
    logic [4:0]  IDEX_rdes;
    logic        IDEX_RegWr;
    logic        IDEX_MemRd;
    logic        IDEX_MemWr;
    logic [5:0]  IDEX_ALUFun;
    logic [31:0] IDEX_busA;
    logic [31:0] IDEX_busB;
    logic [31:0] IDEX_imm;
    logic [31:0] IDEX_PC;
    logic        PC_Wr;
    logic        IFID_Wr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rdes(ID_rdes),
        .ID_uses_rt(ID_uses_rt), .ID_RegWr(ID_RegWr), .ID_MemRd(ID_MemRd),
        .ID_MemWr(ID_MemWr), .ID_ALUFun(ID_ALUFun), .ID_busA(ID_busA),
        .ID_busB(ID_busB), .ID_imm(ID_imm), .ID_PC(ID_PC),
        .EX_flush(EX_flush), .MEM_busy(MEM_busy),
        .IDEX_valid(IDEX_valid), .IDEX_rs(IDEX_rs), .IDEX_rt(IDEX_rt),
        .IDEX_rdes(IDEX_rdes), .IDEX_RegWr(IDEX_RegWr), .IDEX_MemRd(IDEX_MemRd),
        .IDEX_MemWr(IDEX_MemWr), .IDEX_ALUFun(IDEX_ALUFun), .IDEX_busA(IDEX_busA),
        .IDEX_busB(IDEX_busB), .IDEX_imm(IDEX_imm), .IDEX_PC(IDEX_PC),
        .PC_Wr(PC_Wr), .IFID_Wr(IFID_Wr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    task automatic clear_id();
        ID_valid = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; ID_rdes = 5'd0; ID_uses_rt = 1'b0;
        ID_RegWr = 1'b0; ID_MemRd = 1'b0; ID_MemWr = 1'b0; ID_ALUFun = 6'd0;
        ID_busA = 32'd0; ID_busB = 32'd0; ID_imm = 32'd0; ID_PC = 32'd0;
    endtask

    // Present a load "lw $dst" with source register rs in ID.
    task automatic drive_lw(input logic [4:0] dst, input logic [4:0] src);
        clear_id();
        ID_valid = 1'b1; ID_rs = src; ID_rdes = dst; ID_RegWr = 1'b1; ID_MemRd = 1'b1;
        ID_imm = 32'h10; ID_PC = 32'h200;
    endtask

    task automatic drive_alu(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                             input logic [4:0] dst, input logic [31:0] a);
        clear_id();
        ID_valid = 1'b1; ID_rs = rs; ID_rt = rt; ID_uses_rt = uses_rt; ID_rdes = dst;
        ID_RegWr = 1'b1; ID_ALUFun = 6'h20; ID_busA = a; ID_busB = 32'h5;
    endtask

    task automatic stall_inc();
`ifdef HAZARD_STATS_EN
        exp_stall++;
`endif
    endtask

    task automatic flush_inc();
`ifdef HAZARD_STATS_EN
        exp_flush++;
`endif
    endtask

    initial begin
        // Reset with MEM_busy high: fetch enables must still be asserted.
        clear_id();
        EX_flush = 1'b0;
        MEM_busy = 1'b1;
        rst_n    = 1'b0;
        #2;
        chk("rst_valid", 32'(IDEX_valid), 32'd0);
        chk("rst_pcwr", 32'(PC_Wr), 32'd1);
        chk("rst_ifidwr", 32'(IFID_Wr), 32'd1);
        chk_cnt("rst");
        @(negedge clk);
        rst_n    = 1'b1;
        MEM_busy = 1'b0;

        // Normal load
        clear_id();
        ID_valid = 1'b1; ID_rdes = 5'd8; ID_RegWr = 1'b1; ID_busA = 32'h1234;
        ID_rs = 5'd1; ID_rt = 5'd2; ID_ALUFun = 6'h21; ID_busB = 32'h5678;
        ID_imm = 32'h9; ID_PC = 32'h100;
        #1;
        chk("norm_pcwr", 32'(PC_Wr), 32'd1);
        chk("norm_ifidwr", 32'(IFID_Wr), 32'd1);
        @(negedge clk);
        chk("norm_valid", 32'(IDEX_valid), 32'd1);
        chk("norm_rdes", 32'(IDEX_rdes), 32'd8);
        chk("norm_busA", IDEX_busA, 32'h1234);
        chk("norm_busB", IDEX_busB, 32'h5678);
        chk("norm_regwr", 32'(IDEX_RegWr), 32'd1);
        chk("norm_memrd", 32'(IDEX_MemRd), 32'd0);
        chk("norm_alufun", 32'(IDEX_ALUFun), 32'h21);
        chk("norm_pc", IDEX_PC, 32'h100);
        chk("norm_rs", 32'(IDEX_rs), 32'd1);

        // Load-use on rs
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        chk("lw_memrd", 32'(IDEX_MemRd), 32'd1);
        drive_alu(5'd9, 5'd0, 1'b0, 5'd10, 32'hAAAA);
        #1;
        chk("lu_pcwr", 32'(PC_Wr), 32'd0);
        chk("lu_ifidwr", 32'(IFID_Wr), 32'd0);
        @(negedge clk);
        stall_inc();
        chk("lu_bub_valid", 32'(IDEX_valid), 32'd0);
        chk("lu_bub_rdes", 32'(IDEX_rdes), 32'd0);
        chk("lu_bub_regwr", 32'(IDEX_RegWr), 32'd0);
        chk("lu_bub_busA", IDEX_busA, 32'd0);
        #1;
        chk("lu_release_pcwr", 32'(PC_Wr), 32'd1);
        @(negedge clk);
        chk("lu_cons_valid", 32'(IDEX_valid), 32'd1);
        chk("lu_cons_rdes", 32'(IDEX_rdes), 32'd10);
        chk("lu_cons_busA", IDEX_busA, 32'hAAAA);
        chk_cnt("lu");

        // rt match gated by ID_uses_rt
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        drive_alu(5'd4, 5'd9, 1'b0, 5'd11, 32'h1);
        #1;
        chk("rtgate_pcwr", 32'(PC_Wr), 32'd1);
        @(negedge clk);
        chk("rtgate_valid", 32'(IDEX_valid), 32'd1);
        chk("rtgate_rdes", 32'(IDEX_rdes), 32'd11);
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        drive_alu(5'd4, 5'd9, 1'b1, 5'd12, 32'h2);
        #1;
        chk("rtuse_pcwr", 32'(PC_Wr), 32'd0);
        @(negedge clk);
        stall_inc();
        chk("rtuse_valid", 32'(IDEX_valid), 32'd0);

        // Flush together with load-use
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        drive_alu(5'd9, 5'd0, 1'b0, 5'd13, 32'h3);
        EX_flush = 1'b1;
        #1;
        chk("fl_pcwr", 32'(PC_Wr), 32'd1);
        chk("fl_ifidwr", 32'(IFID_Wr), 32'd1);
        @(negedge clk);
        flush_inc();
        chk("fl_valid", 32'(IDEX_valid), 32'd0);
        chk("fl_rdes", 32'(IDEX_rdes), 32'd0);
        chk_cnt("fl");

        // Same with MEM_busy: everything frozen
        EX_flush = 1'b0;
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        drive_alu(5'd9, 5'd0, 1'b0, 5'd13, 32'h3);
        EX_flush = 1'b1;
        MEM_busy = 1'b1;
        #1;
        chk("busy_pcwr", 32'(PC_Wr), 32'd0);
        chk("busy_ifidwr", 32'(IFID_Wr), 32'd0);
        @(negedge clk);
        chk("busy_valid", 32'(IDEX_valid), 32'd1);
        chk("busy_rdes", 32'(IDEX_rdes), 32'd9);
        chk("busy_memrd", 32'(IDEX_MemRd), 32'd1);
        chk("busy_pc", IDEX_PC, 32'h200);
        chk_cnt("busy");

        // lw $0 never causes a stall
        EX_flush = 1'b0;
        MEM_busy = 1'b0;
        drive_lw(5'd0, 5'd1);
        #1;
        chk("lw0_load_pcwr", 32'(PC_Wr), 32'd1);
        @(negedge clk);
        chk("lw0_memrd", 32'(IDEX_MemRd), 32'd1);
        chk("lw0_rdes", 32'(IDEX_rdes), 32'd0);
        drive_alu(5'd0, 5'd0, 1'b1, 5'd14, 32'h4);
        #1;
        chk("zero_pcwr", 32'(PC_Wr), 32'd1);
        @(negedge clk);
        chk("zero_valid", 32'(IDEX_valid), 32'd1);
        chk("zero_rdes", 32'(IDEX_rdes), 32'd14);

        // Asynchronous reset in the middle of a frozen stall
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        drive_alu(5'd9, 5'd0, 1'b0, 5'd15, 32'hBBBB);
        MEM_busy = 1'b1;
        #1;
        chk("prerst_pcwr", 32'(PC_Wr), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("mrst_valid", 32'(IDEX_valid), 32'd0);
        chk("mrst_memrd", 32'(IDEX_MemRd), 32'd0);
        chk("mrst_pcwr", 32'(PC_Wr), 32'd1);
        chk("mrst_ifidwr", 32'(IFID_Wr), 32'd1);
        chk_cnt("mrst");
        @(negedge clk);
        rst_n    = 1'b1;
        MEM_busy = 1'b0;
        #1;
        chk("postrst_pcwr", 32'(PC_Wr), 32'd1);
        @(negedge clk);
        chk("postrst_valid", 32'(IDEX_valid), 32'd1);
        chk("postrst_rdes", 32'(IDEX_rdes), 32'd15);
        chk("postrst_busA", IDEX_busA, 32'hBBBB);

`ifdef HAZARD_STATS_EN
        // Saturation of the stall counter
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        drive_lw(5'd9, 5'd3);
        @(negedge clk);
        drive_alu(5'd9, 5'd0, 1'b0, 5'd16, 32'h5);
        @(negedge clk);
        chk("sat_valid", 32'(IDEX_valid), 32'd0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
